// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE registers, fixed-priority selection and the CPU request/ack handshake.
// Define INTC_EDGE_DETECT_EN to set IF bits on source rising edges instead of on every high cycle.
`ifndef IF
`define IF 16'hFF0F
`endif
`ifndef IE
`define IE 16'hFFFF
`endif

module interrupt_controller #(
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET_L,
  input  logic [15:0] I_ADDR,
  inout  wire  [7:0]  IO_DATA,
  input  logic        I_RE_L,
  input  logic        I_WE_L,
  input  logic        I_VBLANK_INT,
  input  logic        I_LCDC_INT,
  input  logic        I_TIMER_INT,
  input  logic        I_SERIAL_INT,
  input  logic        I_JOYPAD_INT,
  input  logic        I_IME,
  input  logic        I_INT_ACK,
  output logic        O_INT_REQ,
  output logic        O_INT_PENDING,
  output logic [15:0] O_INT_VECTOR,
  output logic [7:0]  O_IF_DATA,
  output logic [7:0]  O_IE_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_SERVICE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic [15:0] vec_q, vec_d;

  logic        if_sel, ie_sel, bus_rd, if_wr, ie_wr;
  logic [4:0]  src, hw_set, pending, req_win, ack_win, ack_clr;
  logic [4:0]  ack_eff_if, ack_eff_ie;
  logic [15:0] req_vec, ack_vec;
  logic [15:0] vec_tab [5];

  // Bus decode
  assign if_sel = (I_ADDR == `IF);
  assign ie_sel = (I_ADDR == `IE);
  assign bus_rd = ~I_RE_L & I_WE_L & (if_sel | ie_sel);
  assign if_wr  = ~I_WE_L & if_sel;
  assign ie_wr  = ~I_WE_L & ie_sel;

  assign IO_DATA = bus_rd ? (if_sel ? {3'b111, if_q} : ie_q) : 8'hzz;

  assign src = {I_JOYPAD_INT, I_SERIAL_INT, I_TIMER_INT, I_LCDC_INT, I_VBLANK_INT};

`ifdef INTC_EDGE_DETECT_EN
  logic [4:0] src_q, src_d;

  always_comb begin
    src_d = src;
  end

  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_L) begin
      src_q <= '0;
    end else begin
      src_q <= src_d;
    end
  end

  assign hw_set = src & ~src_q;
`else
  assign hw_set = src;
`endif

  for (genvar gi = 0; gi < 5; gi++) begin : g_vec
    assign vec_tab[gi] = 16'(VECTOR_BASE + 16'(gi * VECTOR_STRIDE));
  end

  assign pending = if_q & ie_q[4:0];

  // An ack sees a same-cycle IF/IE write, so a write of 0 cancels the dispatch.
  assign ack_eff_if = if_wr ? IO_DATA[4:0] : if_q;
  assign ack_eff_ie = ie_wr ? IO_DATA[4:0] : ie_q[4:0];

  // Isolate lowest set bit: lowest index has highest priority.
  assign req_win = pending & (~pending + 5'd1);
  assign ack_win = (ack_eff_if & ack_eff_ie) & (~(ack_eff_if & ack_eff_ie) + 5'd1);

  always_comb begin
    req_vec = 16'h0000;
    ack_vec = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      if (req_win[k]) req_vec = req_vec | vec_tab[k];
      if (ack_win[k]) ack_vec = ack_vec | vec_tab[k];
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ack_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (I_IME && (pending != '0)) state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (I_INT_ACK) begin
          ack_clr = ack_win;
          vec_d   = ack_vec;
          state_d = ST_SERVICE;
        end else if (!I_IME || (pending == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (!I_IME) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hardware set dominates both software writes and the ack clear.
  always_comb begin
    ie_d = ie_wr ? IO_DATA : ie_q;
    if_d = '0;
    for (int k = 0; k < 5; k++) begin
      if_d[k] = hw_set[k] | (if_wr ? IO_DATA[k] : (if_q[k] & ~ack_clr[k]));
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_L) begin
      state_q <= ST_IDLE;
      if_q    <= '0;
      ie_q    <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      if_q    <= if_d;
      ie_q    <= ie_d;
      vec_q   <= vec_d;
    end
  end

  assign O_INT_REQ     = (state_q == ST_REQUEST);
  assign O_INT_PENDING = |pending;
  assign O_INT_VECTOR  = (state_q == ST_REQUEST) ? req_vec : vec_q;
  assign O_IF_DATA     = {3'b111, if_q};
  assign O_IE_DATA     = ie_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Owns the IF (interrupt flag) and IE (interrupt enable) registers on the I/O bus.
- Collects interrupt pulses from the timer, LCD, serial and joypad blocks.
- Selects the highest-priority pending interrupt and runs a request/acknowledge handshake with the CPU.
- Supplies the dispatch vector to the CPU and clears the serviced IF bit.

Parameters:
- VECTOR_BASE, 16'h0040, vector of source 0 (VBLANK).
- VECTOR_STRIDE, 8, address spacing between consecutive source vectors.

Ports:
- I_CLOCK  input  1  system clock (2^23 Hz domain)
- I_RESET_L  input  1  synchronous, active-low reset
- I_ADDR  input  16  CPU address bus
- IO_DATA  inout  8  CPU data bus; driven only during a read of IF or IE, else high-Z
- I_RE_L  input  1  bus read enable, active-low
- I_WE_L  input  1  bus write enable, active-low
- I_VBLANK_INT  input  1  source 0 request (IF bit 0)
- I_LCDC_INT  input  1  source 1 request (IF bit 1)
- I_TIMER_INT  input  1  source 2 request (IF bit 2), from the timer's O_TIMER_INTERRUPT
- I_SERIAL_INT  input  1  source 3 request (IF bit 3)
- I_JOYPAD_INT  input  1  source 4 request (IF bit 4)
- I_IME  input  1  CPU master interrupt enable
- I_INT_ACK  input  1  CPU dispatch acknowledge; one-cycle pulse
- O_INT_REQ  output  1  interrupt request to the CPU
- O_INT_PENDING  output  1  (IE & IF & 5'h1F) != 0, independent of IME; used for HALT wake
- O_INT_VECTOR  output  16  dispatch address
- O_IF_DATA  output  8  debug copy of the IF read value
- O_IE_DATA  output  8  debug copy of IE

Behaviour:
- Reset (I_RESET_L=0 at posedge):
  - IF[4:0]=0, IE=8'h00, state=IDLE.
  - O_INT_REQ=0, O_INT_VECTOR=16'h0000.
  - All register updates are synchronous to I_CLOCK.
- Addressing: IF is at address `IF (0xFF0F); IE is at address `IE (0xFFFF). Both come from memdef.vh.
- Register reads:
  - IF reads as {3'b111, IF[4:0]}.
  - IE reads as the full 8 bits.
- Register writes:
  - IF write loads IO_DATA[4:0]; upper bits are ignored.
  - IE write stores all 8 bits.
- Next IF bit = hardware set OR (write ? written value : (clear ? 0 : current)).
  - A hardware set in the same cycle as a write of 0 or an ack-clear leaves the bit at 1.
- Priority: lowest bit index wins (VBLANK highest, JOYPAD lowest).
- Vector for source k = VECTOR_BASE + k*VECTOR_STRIDE, i.e. 0x40, 0x48, 0x50, 0x58, 0x60.
- State machine (registered):
  - IDLE:
    - O_INT_REQ=0.
    - Go to REQUEST when I_IME=1 and pending != 0.
  - REQUEST:
    - O_INT_REQ=1.
    - O_INT_VECTOR tracks the current highest-priority pending source each cycle.
    - If pending becomes 0 (IF or IE write) with no ack, return to IDLE next cycle.
    - If I_IME falls with no ack, return to IDLE.
    - On I_INT_ACK: latch the vector of the winning source, clear that IF bit in the same edge, go to SERVICE.
    - Ack with nothing pending (cancelled dispatch): latch O_INT_VECTOR=16'h0000, clear no bit, go to SERVICE.
  - SERVICE:
    - O_INT_REQ=0; O_INT_VECTOR holds the latched value.
    - Wait for I_IME=0 (CPU has cleared IME), then go to IDLE.
- I_INT_ACK in IDLE or SERVICE is ignored.
- Reset mid-handshake: immediately returns to the reset state; the in-flight ack is lost.
- O_IF_DATA and O_IE_DATA always reflect the register values, no latency.

Optional Feature:
- Macro: INTC_EDGE_DETECT_EN.
- Defined:
  - Each source input is registered; an IF bit sets only on a 0->1 transition of its source.
  - A level held high sets the bit once; after software clears it, the bit stays clear until the source drops and rises again.
  - Edge registers reset to 0.
- Undefined:
  - An IF bit sets in every cycle its source input is 1.
  - Sources must deliver one-cycle pulses.

Test Plan:
- Reset, read 0xFF0F and 0xFFFF -> IO_DATA = 8'hE0 and 8'h00; O_INT_REQ=0; O_INT_VECTOR=0x0000.
- IE=0x04, I_IME=1, one-cycle I_TIMER_INT pulse -> IF reads 0xE4; O_INT_REQ=1 next cycle; vector 0x0050. Then I_INT_ACK pulse -> IF reads 0xE0, vector held at 0x0050; after I_IME=0, state returns to IDLE.
- IE=0x1F, I_TIMER_INT and I_VBLANK_INT in the same cycle, I_IME=1 -> vector 0x0040. After ack, IF reads 0xE4 and a new request with vector 0x0050 follows once I_IME returns to 1.
- In REQUEST (timer pending), CPU writes IF=0x00 in the same cycle as I_INT_ACK -> O_INT_VECTOR=0x0000 and no IF bit set.
- CPU writes IF=0x00 in the same cycle as an I_TIMER_INT pulse -> IF reads 0xE4.
- I_IME=0, IE=0x01, I_VBLANK_INT pulse -> O_INT_PENDING=1, O_INT_REQ stays 0. With INTC_EDGE_DETECT_EN, I_JOYPAD_INT held high for 10 cycles and IF cleared at cycle 5 -> IF bit 4 remains 0.
